serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor: accepts two WIDTH-bit operands and a borrow-in over a valid/ready handshake. It processes them LSB-first through a single full-subtractor cell with a registered borrow, one bit per clock. It returns the difference and borrow-out over a second valid/ready handshake. It is the inverse-operation counterpart of the team's full-adder datapath cell, for area-constrained arithmetic where one bit per cycle is acceptable.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- in_valid, input, 1: operand bundle valid.
- in_ready, output, 1: block can accept operands; high only in IDLE.
- a, input, WIDTH: minuend, unsigned.
- b, input, WIDTH: subtrahend, unsigned.
- bin, input, 1: borrow-in.
- out_valid, output, 1: result valid; high only in DONE.
- out_ready, input, 1: consumer accepts result.
- diff, output, WIDTH: (a - b - bin) mod 2^WIDTH.
- bout, output, 1: borrow-out; 1 iff a < b + bin (unsigned, evaluated exactly).
- busy, output, 1: high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE. Reset enters IDLE.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

IDLE:
- in_ready=1.
- On in_valid & in_ready at an edge:
  - capture a, b into shift registers;
  - load the borrow register with bin;
  - clear the bit counter;
  - go to SHIFT.

SHIFT:
- Each cycle consumes bit 0 of the a/b shift registers (x=a0, y=b0, r=borrow).
- d = x ^ y ^ r.
- borrow_next = (~x & y) | (~x & r) | (y & r).
- d shifts into the result register from the MSB side, so that after WIDTH shifts bit i of the result equals bit i of the difference.
- The counter increments each cycle. On the edge that processes bit WIDTH-1, go to DONE and latch the final borrow into bout.

DONE:
- out_valid=1; diff and bout are held stable.
- On out_valid & out_ready at an edge, go to IDLE.
- diff and bout keep their last values until the next result is latched; they are not cleared on handshake.

Input handling:
- in_valid outside IDLE is ignored; no queuing.
- Operand inputs are sampled only at the accepting edge. Later changes on a/b/bin have no effect.

Arithmetic:
- Counter width is clog2(WIDTH)+1, with no wrap ambiguity.
- The result equals the full-width two's-complement subtraction truncated to WIDTH bits.
- bout is the carry-complement of a + ~b + ~bin.

## Timing
Reset values (asynchronous; they appear without a clock edge):
- in_ready=1, out_valid=0, busy=0, diff=0, bout=0.
- Internal shift registers, borrow register and counter = 0.

Reset mid-operation (SHIFT or DONE):
- Aborts immediately; no out_valid is produced for the aborted operation.
- The first edge after rst deasserts may accept a new operand.

Latency and throughput:
- Accept at edge E0; out_valid rises after edge E(WIDTH), so latency is exactly WIDTH cycles from acceptance.
- With out_ready held high: DONE lasts 1 cycle, in_ready rises after edge E(WIDTH+1). Minimum initiation interval is WIDTH+2 cycles.
- out_ready low: the block stalls in DONE indefinitely, with outputs stable and in_ready=0.
- in_ready and out_valid are never high in the same cycle.

## Test plan
- WIDTH=8, a=8'h5A, b=8'h3C, bin=0 -> diff=8'h1E, bout=0. out_valid first high exactly 8 cycles after the accepting edge; busy high for the whole transaction.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1 (wrap). Then a=8'hFF, b=8'hFF, bin=1 -> diff=8'hFF, bout=1.
- a=8'h80, b=8'h7F, bin=1 -> diff=8'h00, bout=0 (borrow ripples across all bits).
- out_ready held low 5 cycles in DONE, with in_valid pulsed and a/b changed during SHIFT and DONE:
  - diff, bout and out_valid stay stable and in_ready stays 0;
  - the stray inputs are ignored;
  - the next accept occurs only after the handshake.
- rst asserted asynchronously mid-SHIFT after 3 bits:
  - all outputs go to reset values before the next edge;
  - no out_valid is produced;
  - a following op a=8'h10, b=8'h01, bin=0 returns diff=8'h0F, bout=0.
- Back-to-back ops with in_valid and out_ready tied high: initiation interval is exactly 10 cycles. 1000 random a/b/bin vectors match the reference model (a-b-bin) mod 256 and borrow.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first.
// Ports: clk, rst (async high), in_valid/in_ready + a, b, bin operand
//   handshake; out_valid/out_ready + diff, bout result handshake; busy.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             brw_q, brw_d;
   logic             bout_q, bout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic x, y, r, d, bn, last;

   assign x    = a_q[0];
   assign y    = b_q[0];
   assign r    = brw_q;
   assign d    = x ^ y ^ r;
   assign bn   = (~x & y) | (~x & r) | (y & r);
   assign last = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sh_q    <= '0;
         diff_q  <= '0;
         brw_q   <= 1'b0;
         bout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sh_q    <= sh_d;
         diff_q  <= diff_d;
         brw_q   <= brw_d;
         bout_q  <= bout_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sh_d    = sh_q;
      diff_d  = diff_q;
      brw_d   = brw_q;
      bout_d  = bout_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               brw_d   = bin;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // Difference bits enter at the MSB so bit i lands at
            // position i after WIDTH shifts.
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            sh_d  = {d, sh_q[WIDTH-1:1]};
            brw_d = bn;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               // Visible result only changes here, so diff/bout stay
               // stable through SHIFT and DONE of the next operation.
               diff_d  = {d, sh_q[WIDTH-1:1]};
               bout_d  = bn;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign diff      = diff_q;
   assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed cases,
// stall, async reset abort, and random back-to-back traffic.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         bout;
   logic         busy;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   last_acc = -1;
   logic ov_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(input logic [W-1:0] ma,
                                  input logic [W-1:0] mb,
                                  input logic mbin);
      exp_t e;
      int   v;
      v    = int'(ma) - int'(mb) - int'(mbin);
      e.d  = W'(v & ((1 << W) - 1));
      e.bo = (v < 0);
      e.acc = 0;
      return e;
   endfunction

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tbin);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
      end else begin
         a = ta;
         b = tb_;
         bin = tbin;
         in_valid = 1'b1;
         e = model(ta, tb_, tbin);
         e.acc = cyc + 1;
         last_acc = e.acc;
         q.push_back(e);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) chk("drain_timeout", q.size(), 0);
   endtask

   // Monitor: compares on every result handshake, checks latency on
   // each rising out_valid and handshake exclusivity every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            chk("ready_valid_excl", {31'b0, in_ready & out_valid}, 0);
            if (out_valid && !ov_prev) begin
               if (q.size() == 0) chk("unexpected_valid", 1, 0);
               else chk("latency", cyc - q[0].acc, W);
            end
            if (out_valid && out_ready && q.size() > 0) begin
               e = q.pop_front();
               chk("diff", {24'b0, diff}, {24'b0, e.d});
               chk("bout", {31'b0, bout}, {31'b0, e.bo});
            end
         end
         ov_prev = out_valid;
      end
   end

   initial begin
      exp_t e;
      int   n;
      int   prev;
      logic [W-1:0] hd;
      logic         hb;

      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_diff", {24'b0, diff}, 0);
      chk("rst_bout", {31'b0, bout}, 0);
      #11 rst = 1'b0;

      // Directed: 5A-3C, busy through the whole transaction.
      out_ready = 1'b1;
      send(8'h5A, 8'h3C, 1'b0);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         chk("busy_shift", {31'b0, busy}, 1);
         @(negedge clk);
         n++;
      end
      chk("busy_done", {31'b0, busy}, 1);
      drain();

      send(8'h00, 8'h01, 1'b0);
      in_valid = 1'b0;
      send(8'hFF, 8'hFF, 1'b1);
      in_valid = 1'b0;
      send(8'h80, 8'h7F, 1'b1);
      in_valid = 1'b0;
      drain();

      // Stall in DONE with stray in_valid and operand changes.
      out_ready = 1'b0;
      send(8'hC3, 8'h5E, 1'b1);
      e = model(8'hC3, 8'h5E, 1'b1);
      n = 0;
      while (!out_valid && n < 30) begin
         @(negedge clk);
         in_valid = 1'b1;
         a = W'($urandom);
         b = W'($urandom);
         bin = 1'($urandom);
         n++;
      end
      #2;
      hd = diff;
      hb = bout;
      chk("stall_diff_val", {24'b0, hd}, {24'b0, e.d});
      chk("stall_bout_val", {31'b0, hb}, {31'b0, e.bo});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         a = W'($urandom);
         b = W'($urandom);
         #2;
         chk("stall_valid", {31'b0, out_valid}, 1);
         chk("stall_ready", {31'b0, in_ready}, 0);
         chk("stall_diff", {24'b0, diff}, {24'b0, e.d});
         chk("stall_bout", {31'b0, bout}, {31'b0, e.bo});
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_hs_ready", {31'b0, in_ready}, 1);
      drain();

      // Async reset three bits into SHIFT.
      send(8'h77, 8'h22, 1'b0);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_in_ready", {31'b0, in_ready}, 1);
      chk("abort_out_valid", {31'b0, out_valid}, 0);
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_diff", {24'b0, diff}, 0);
      chk("abort_bout", {31'b0, bout}, 0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      send(8'h10, 8'h01, 1'b0);
      in_valid = 1'b0;
      drain();

      // Back-to-back random traffic; initiation interval is W+2.
      out_ready = 1'b1;
      prev = -1;
      for (int i = 0; i < 1000; i++) begin
         send(W'($urandom), W'($urandom), 1'($urandom));
         if (prev >= 0) chk("ii", last_acc - prev, W + 2);
         prev = last_acc;
      end
      in_valid = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
